spi_word_cmd_sequencer: RTL and testbench

//  Command sequencer behind the 64-bit SPI word engine (SPIWord). Consumes each received word.

---
 rtl/spi_word_cmd_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_spi_word_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_cmd_sequencer.sv
// Command sequencer behind the 64-bit SPI word engine: header decode, WRITE/READ register bursts, status word.
// Optional build macro CMD_CHECKSUM_EN: header [7:0] must equal the XOR of header bytes [63:8].
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a header word; word_send_data tracks STATUS
// ST_WRITE | each received word is written to the bank at the burst address
// ST_READ  | bank data is loaded into word_send_data; payload words ignored
module spi_word_cmd_sequencer #(
    parameter int         NUM_REGS     = 8,
    parameter int         MAX_PAYLOAD  = 4,
    parameter logic [7:0] STATUS_MAGIC = 8'hA5
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        CS,
    input  logic                        word_received,
    input  logic [63:0]                 word_data_received,
    output logic [63:0]                 word_send_data,
    output logic                        reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
    output logic [63:0]                 reg_wr_data,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    input  logic [63:0]                 reg_rd_data,
    output logic                        busy,
    output logic                        cmd_error,
    output logic [7:0]                  err_count
);

    localparam int         AW       = $clog2(NUM_REGS);
    localparam logic [7:0] MAX_N    = MAX_PAYLOAD[7:0];
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t         state_r, state_n;
    logic [AW-1:0]  addr_r, addr_n;
    logic [7:0]     cnt_r, cnt_n;
    logic           cs_q;
    logic [1:0]     rd_pipe, pipe_n;
    logic           err_pend, err_pend_n;

    logic [63:0]    send_n;
    logic           wr_en_n;
    logic [AW-1:0]  wr_addr_n;
    logic [63:0]    wr_data_n;
    logic [AW-1:0]  rd_addr_n;
    logic           err_flag_n;
    logic [7:0]     err_count_n;
    logic [1:0]     inc;
    logic [8:0]     err_sum;
    logic           hdr_err;

    logic [7:0]     hdr_op;
    logic [AW-1:0]  hdr_addr;
    logic [7:0]     hdr_n;
    logic           chk_ok;
    logic           cs_rise;

    assign hdr_op   = word_data_received[63:56];
    assign hdr_addr = word_data_received[48 +: AW];
    assign hdr_n    = word_data_received[47:40];
    assign cs_rise  = CS & ~cs_q;
    assign busy     = (state_r != ST_IDLE);

`ifdef CMD_CHECKSUM_EN
    logic [7:0] hdr_xor;
    assign hdr_xor = word_data_received[63:56] ^ word_data_received[55:48]
                   ^ word_data_received[47:40] ^ word_data_received[39:32]
                   ^ word_data_received[31:24] ^ word_data_received[23:16]
                   ^ word_data_received[15:8];
    assign chk_ok  = (word_data_received[7:0] == hdr_xor);
`else
    assign chk_ok  = 1'b1;
`endif

    always_comb begin
        state_n    = state_r;
        addr_n     = addr_r;
        cnt_n      = cnt_r;
        pipe_n     = {rd_pipe[0], 1'b0};
        err_pend_n = 1'b0;
        send_n     = word_send_data;
        wr_en_n    = 1'b0;
        wr_addr_n  = reg_wr_addr;
        wr_data_n  = reg_wr_data;
        rd_addr_n  = reg_rd_addr;
        hdr_err    = 1'b0;
        inc        = 2'd0;

        case (state_r)
            ST_IDLE: begin
                if (word_received) begin
                    if (!chk_ok) begin
                        hdr_err = 1'b1;
                    end else begin
                        case (hdr_op)
                            OP_NOP: begin
                            end
                            OP_WRITE, OP_READ: begin
                                if (hdr_n > MAX_N) begin
                                    hdr_err = 1'b1;
                                end else if (hdr_n != 8'd0) begin
                                    addr_n = hdr_addr;
                                    cnt_n  = hdr_n;
                                    if (hdr_op == OP_WRITE) begin
                                        state_n = ST_WRITE;
                                    end else begin
                                        state_n   = ST_READ;
                                        rd_addr_n = hdr_addr;
                                        pipe_n    = 2'b01;
                                    end
                                end
                            end
                            default: hdr_err = 1'b1;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                if (word_received) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr_r;
                    wr_data_n = word_data_received;
                    addr_n    = addr_r + ADDR_ONE;
                    cnt_n     = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (word_received) begin
                    addr_n    = addr_r + ADDR_ONE;
                    rd_addr_n = addr_r + ADDR_ONE;
                    cnt_n     = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        state_n = ST_IDLE;
                        pipe_n  = 2'b00;
                    end else begin
                        pipe_n  = {rd_pipe[0], 1'b1};
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Abort after the coincident word is handled; the error is raised a cycle
        // later so it never lands on the same cycle as that word's write strobe.
        if (cs_rise && (state_r != ST_IDLE) && (state_n != ST_IDLE)) begin
            state_n    = ST_IDLE;
            pipe_n     = 2'b00;
            err_pend_n = 1'b1;
        end

        // Bank data is valid two cycles after reg_rd_addr moves.
        if (rd_pipe[1] && (state_n == ST_READ)) begin
            send_n = reg_rd_data;
        end
        if (state_n == ST_IDLE) begin
            send_n = {STATUS_MAGIC, 6'b0, state_n, err_count, 40'b0};
        end

        if (hdr_err) begin
            inc = inc + 2'd1;
        end
        if (err_pend) begin
            inc = inc + 2'd1;
        end
        err_flag_n  = hdr_err | err_pend;
        err_sum     = {1'b0, err_count} + {7'b0, inc};
        err_count_n = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            addr_r         <= '0;
            cnt_r          <= 8'd0;
            cs_q           <= 1'b1;
            rd_pipe        <= 2'b00;
            err_pend       <= 1'b0;
            word_send_data <= {STATUS_MAGIC, 56'b0};
            reg_wr_en      <= 1'b0;
            reg_wr_addr    <= '0;
            reg_wr_data    <= 64'd0;
            reg_rd_addr    <= '0;
            cmd_error      <= 1'b0;
            err_count      <= 8'd0;
        end else begin
            state_r        <= state_n;
            addr_r         <= addr_n;
            cnt_r          <= cnt_n;
            cs_q           <= CS;
            rd_pipe        <= pipe_n;
            err_pend       <= err_pend_n;
            word_send_data <= send_n;
            reg_wr_en      <= wr_en_n;
            reg_wr_addr    <= wr_addr_n;
            reg_wr_data    <= wr_data_n;
            reg_rd_addr    <= rd_addr_n;
            cmd_error      <= err_flag_n;
            err_count      <= err_count_n;
        end
    end

endmodule

// File: tb/tb_spi_word_cmd_sequencer.sv
// Directed self-checking bench for spi_word_cmd_sequencer with a registered 8-entry register bank model.
// Honours CMD_CHECKSUM_EN in the checksum scenario.
module tb_spi_word_cmd_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        CS;
    logic        word_received;
    logic [63:0] word_data_received;
    logic [63:0] word_send_data;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_addr;
    logic [63:0] reg_wr_data;
    logic [2:0]  reg_rd_addr;
    logic [63:0] reg_rd_data;
    logic        busy;
    logic        cmd_error;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    int          wr_n = 0;
    int          err_pulses = 0;
    logic [2:0]  wr_a_log [0:63];
    logic [63:0] wr_d_log [0:63];
    logic [63:0] bank [0:7];

    spi_word_cmd_sequencer dut (
        .clk                (clk),
        .resetn             (resetn),
        .CS                 (CS),
        .word_received      (word_received),
        .word_data_received (word_data_received),
        .word_send_data     (word_send_data),
        .reg_wr_en          (reg_wr_en),
        .reg_wr_addr        (reg_wr_addr),
        .reg_wr_data        (reg_wr_data),
        .reg_rd_addr        (reg_rd_addr),
        .reg_rd_data        (reg_rd_data),
        .busy               (busy),
        .cmd_error          (cmd_error),
        .err_count          (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_wr_en) bank[reg_wr_addr] <= reg_wr_data;
        reg_rd_data <= bank[reg_rd_addr];
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (reg_wr_en) begin
                if (wr_n < 64) begin
                    wr_a_log[wr_n] = reg_wr_addr;
                    wr_d_log[wr_n] = reg_wr_data;
                end
                wr_n = wr_n + 1;
            end
            if (cmd_error) err_pulses = err_pulses + 1;
        end
    end

    function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] a, input logic [7:0] n);
        logic [63:0] h;
        h = {op, a, n, 40'b0};
        h[7:0] = op ^ a ^ n;
        return h;
    endfunction

    task automatic send_word(input logic [63:0] w, input logic cs_with);
        @(posedge clk); #1;
        word_data_received = w;
        word_received = 1'b1;
        if (cs_with) CS = 1'b1;
        @(posedge clk); #1;
        word_received = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        CS = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_pulse();
        @(posedge clk); #1;
        CS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        CS = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        CS = 1'b0;
        word_received = 1'b0;
        word_data_received = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (reg_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL reset_cmd_error: got %b want 0", cmd_error); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count: got %0h want 0", err_count); end
        total++; if (word_send_data !== 64'hA500_0000_0000_0000) begin bad++; $display("FAIL reset_status: got %h want a500000000000000", word_send_data); end
        total++; if ({reg_rd_addr, reg_wr_addr, reg_wr_data} !== 70'd0) begin bad++; $display("FAIL reset_addrs: got rd=%0d wr=%0d data=%h want zeros", reg_rd_addr, reg_wr_addr, reg_wr_data); end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        int w0;
        w0 = wr_n;
        send_word(hdr(8'h01, 8'h00, 8'h03), 1'b0);
        send_word(64'h0000_0000_0000_1234, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midwr_busy: got %b want 1", busy); end
        total++; if (wr_n !== w0 + 1) begin bad++; $display("FAIL midwr_first_write: got %0d want %0d", wr_n, w0 + 1); end
        @(posedge clk); #2;
        resetn = 1'b0;
        @(negedge clk);
        total++; if ({busy, reg_wr_en, cmd_error} !== 3'b000) begin bad++; $display("FAIL midwr_reset_flags: got %b want 000", {busy, reg_wr_en, cmd_error}); end
        total++; if (reg_wr_data !== 64'd0 || reg_wr_addr !== 3'd0) begin bad++; $display("FAIL midwr_reset_wr: got addr=%0d data=%h want 0", reg_wr_addr, reg_wr_data); end
        total++; if (word_send_data[63:56] !== 8'hA5) begin bad++; $display("FAIL midwr_reset_magic: got %h want a5", word_send_data[63:56]); end
        @(posedge clk); #1;
        resetn = 1'b1;
        w0 = wr_n;
        send_word(hdr(8'h01, 8'h01, 8'h01), 1'b0);
        send_word(64'h55, 1'b0);
        total++; if (wr_n !== w0 + 1 || wr_a_log[w0] !== 3'd1 || wr_d_log[w0] !== 64'h55) begin bad++; $display("FAIL midwr_after_reset_write: got n=%0d addr=%0d data=%h want n=%0d addr=1 data=55", wr_n - w0, wr_a_log[w0], wr_d_log[w0], 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midwr_after_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_n;
        send_word(hdr(8'h01, 8'h03, 8'h02), 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_hdr: got %b want 1", busy); end
        send_word(64'hbeef_dead_dead_beef, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_mid: got %b want 1", busy); end
        send_word(64'h5f_ffff, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_end: got %b want 0", busy); end
        total++; if (wr_n !== w0 + 2) begin bad++; $display("FAIL write_count: got %0d want 2", wr_n - w0); end
        total++; if (wr_a_log[w0] !== 3'd3 || wr_d_log[w0] !== 64'hbeef_dead_dead_beef) begin bad++; $display("FAIL write_first: got addr=%0d data=%h want 3 beefdeaddeadbeef", wr_a_log[w0], wr_d_log[w0]); end
        total++; if (wr_a_log[w0+1] !== 3'd4 || wr_d_log[w0+1] !== 64'h5f_ffff) begin bad++; $display("FAIL write_second: got addr=%0d data=%h want 4 5fffff", wr_a_log[w0+1], wr_d_log[w0+1]); end
    endtask

    task automatic test_read();
        int w0;
        w0 = wr_n;
        send_word(hdr(8'h01, 8'h07, 8'h03), 1'b0);
        send_word(64'd11, 1'b0);
        send_word(64'd22, 1'b0);
        send_word(64'd33, 1'b0);
        total++; if (wr_a_log[w0+1] !== 3'd0 || wr_a_log[w0+2] !== 3'd1) begin bad++; $display("FAIL read_preload_wrap: got %0d,%0d want 0,1", wr_a_log[w0+1], wr_a_log[w0+2]); end
        w0 = wr_n;
        send_word(hdr(8'h02, 8'h07, 8'h03), 1'b0);
        total++; if (word_send_data !== 64'd11) begin bad++; $display("FAIL read_word0: got %0d want 11", word_send_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy: got %b want 1", busy); end
        send_word(64'hdead, 1'b0);
        total++; if (word_send_data !== 64'd22) begin bad++; $display("FAIL read_word1_wrap: got %0d want 22", word_send_data); end
        send_word(64'hdead, 1'b0);
        total++; if (word_send_data !== 64'd33) begin bad++; $display("FAIL read_word2: got %0d want 33", word_send_data); end
        send_word(64'hdead, 1'b0);
        total++; if (word_send_data !== 64'hA500_0000_0000_0000) begin bad++; $display("FAIL read_status_after: got %h want a500000000000000", word_send_data); end
        total++; if (busy !== 1'b0 || wr_n !== w0) begin bad++; $display("FAIL read_end: got busy=%b writes=%0d want 0 0", busy, wr_n - w0); end
    endtask

    task automatic test_errors();
        int w0, e0;
        w0 = wr_n;
        e0 = err_pulses;
        send_word(hdr(8'h7F, 8'h00, 8'h00), 1'b0);
        send_word(hdr(8'h01, 8'h00, 8'h05), 1'b0);
        total++; if (err_pulses !== e0 + 2) begin bad++; $display("FAIL err_pulses: got %0d want 2", err_pulses - e0); end
        total++; if (err_count !== 8'd2) begin bad++; $display("FAIL err_count: got %0d want 2", err_count); end
        total++; if (wr_n !== w0 || busy !== 1'b0) begin bad++; $display("FAIL err_no_write: got writes=%0d busy=%b want 0 0", wr_n - w0, busy); end
        total++; if (word_send_data !== 64'hA500_0200_0000_0000) begin bad++; $display("FAIL err_status: got %h want a500020000000000", word_send_data); end
        send_word(hdr(8'h02, 8'h00, 8'h00), 1'b0);
        send_word(hdr(8'h00, 8'h00, 8'h00), 1'b0);
        total++; if (err_count !== 8'd2 || busy !== 1'b0) begin bad++; $display("FAIL err_zero_len_nop: got err=%0d busy=%b want 2 0", err_count, busy); end
        send_word(hdr(8'h01, 8'h00, 8'h04), 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL err_max_len_busy: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) send_word(64'h100 + 64'(i), 1'b0);
        total++; if (wr_n !== w0 + 4 || busy !== 1'b0 || err_count !== 8'd2) begin bad++; $display("FAIL err_max_len_done: got writes=%0d busy=%b err=%0d want 4 0 2", wr_n - w0, busy, err_count); end
    endtask

    task automatic test_abort();
        int w0, e0;
        w0 = wr_n;
        e0 = err_pulses;
        send_word(hdr(8'h01, 8'h05, 8'h03), 1'b0);
        send_word(64'hA1, 1'b0);
        cs_pulse();
        total++; if (wr_n !== w0 + 1 || wr_a_log[w0] !== 3'd5) begin bad++; $display("FAIL abort_one_write: got writes=%0d addr=%0d want 1 5", wr_n - w0, wr_a_log[w0]); end
        total++; if (err_pulses !== e0 + 1 || err_count !== 8'd3) begin bad++; $display("FAIL abort_error: got pulses=%0d err=%0d want 1 3", err_pulses - e0, err_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
        cs_pulse();
        total++; if (err_pulses !== e0 + 1 || err_count !== 8'd3) begin bad++; $display("FAIL abort_cs_idle: got pulses=%0d err=%0d want 1 3", err_pulses - e0, err_count); end
        send_word(hdr(8'h01, 8'h06, 8'h01), 1'b0);
        send_word(64'hB2, 1'b0);
        total++; if (wr_n !== w0 + 2 || wr_a_log[w0+1] !== 3'd6 || wr_d_log[w0+1] !== 64'hB2) begin bad++; $display("FAIL abort_next_cmd: got writes=%0d addr=%0d data=%h want 2 6 b2", wr_n - w0, wr_a_log[w0+1], wr_d_log[w0+1]); end
        send_word(hdr(8'h01, 8'h02, 8'h01), 1'b0);
        send_word(64'hC3, 1'b1);
        total++; if (wr_n !== w0 + 3 || err_count !== 8'd3 || busy !== 1'b0) begin bad++; $display("FAIL abort_cs_on_last: got writes=%0d err=%0d busy=%b want 3 3 0", wr_n - w0, err_count, busy); end
        send_word(hdr(8'h01, 8'h02, 8'h02), 1'b0);
        send_word(64'hD4, 1'b1);
        total++; if (wr_n !== w0 + 4 || err_count !== 8'd4 || busy !== 1'b0) begin bad++; $display("FAIL abort_cs_with_word: got writes=%0d err=%0d busy=%b want 4 4 0", wr_n - w0, err_count, busy); end
    endtask

    task automatic test_checksum();
        int w0;
        logic [63:0] h;
        w0 = wr_n;
        h = hdr(8'h01, 8'h02, 8'h01);
        h[7:0] = ~h[7:0];
        send_word(h, 1'b0);
`ifdef CMD_CHECKSUM_EN
        total++; if (err_count !== 8'd5 || busy !== 1'b0) begin bad++; $display("FAIL cksum_bad: got err=%0d busy=%b want 5 0", err_count, busy); end
        send_word(hdr(8'h01, 8'h02, 8'h01), 1'b0);
        send_word(64'hE5, 1'b0);
        total++; if (wr_n !== w0 + 1 || wr_a_log[w0] !== 3'd2 || wr_d_log[w0] !== 64'hE5 || err_count !== 8'd5) begin bad++; $display("FAIL cksum_good: got writes=%0d addr=%0d data=%h err=%0d want 1 2 e5 5", wr_n - w0, wr_a_log[w0], wr_d_log[w0], err_count); end
`else
        total++; if (err_count !== 8'd4 || busy !== 1'b1) begin bad++; $display("FAIL cksum_ignored: got err=%0d busy=%b want 4 1", err_count, busy); end
        send_word(64'hE5, 1'b0);
        total++; if (wr_n !== w0 + 1 || wr_a_log[w0] !== 3'd2 || wr_d_log[w0] !== 64'hE5 || busy !== 1'b0) begin bad++; $display("FAIL cksum_ignored_write: got writes=%0d addr=%0d data=%h busy=%b want 1 2 e5 0", wr_n - w0, wr_a_log[w0], wr_d_log[w0], busy); end
`endif
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) send_word(hdr(8'h7F, 8'h00, 8'h00), 1'b0);
        total++; if (err_count !== 8'hFF) begin bad++; $display("FAIL sat_count: got %0h want ff", err_count); end
        total++; if (word_send_data !== 64'hA500_FF00_0000_0000) begin bad++; $display("FAIL sat_status: got %h want a500ff0000000000", word_send_data); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_write();
        test_read();
        test_errors();
        test_abort();
        test_checksum();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
